// File: rtl/sipo_deser_if.sv
// Link between the serial front end and the word-wide consumer of sipo_deser.
// The master side drives the serial bits and the handshake; the slave side is the deserialiser.
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             si;
  logic             si_en;
  logic             flush;
  logic             pout_ready;
  logic             ovf_clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic [CW-1:0]    bit_cnt;
  logic             overflow;

  modport master (
    output si, si_en, flush, pout_ready, ovf_clr,
    input  pout, pout_valid, bit_cnt, overflow
  );

  modport slave (
    input  si, si_en, flush, pout_ready, ovf_clr,
    output pout, pout_valid, bit_cnt, overflow
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with a one-entry valid/ready output register.
// Shifting never stalls; a word completed while the output is still occupied is dropped and flagged.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sipo_deser_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pout_q;
  logic             valid_q;
  logic             ovf_q;
  logic [WIDTH-1:0] word_next;
  logic             shift;
  logic             complete;
  logic             free;

  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next = {sreg[WIDTH-2:0], bus.si};
    end else begin : g_lsb
      assign word_next = {bus.si, sreg[WIDTH-1:1]};
    end
  endgenerate

  // flush discards the bit on its edge, so it also suppresses completion
  assign shift    = bus.si_en & ~bus.flush;
  assign complete = shift & (cnt == CW'(WIDTH - 1));
  assign free     = ~valid_q | bus.pout_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      cnt     <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (bus.si_en) begin
        sreg <= word_next;
        cnt  <= complete ? '0 : cnt + CW'(1);
      end

      if (complete && free) begin
        pout_q  <= word_next;
        valid_q <= 1'b1;
      end else if (valid_q && bus.pout_ready) begin
        valid_q <= 1'b0;
      end

      // a drop on the same edge as a clear leaves the flag set
      if (complete && !free) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = valid_q;
  assign bus.bit_cnt    = cnt;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: 4-bit MSB-first and LSB-first instances fed the same stream, plus an 8-bit instance.
// Expected words are queued when their last bit is driven and checked when the consumer takes them.
module tb_sipo_deser;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  logic [3:0] q_m[$];
  logic [3:0] q_l[$];
  logic [7:0] q_8[$];

  sipo_deser_if #(.WIDTH(4)) b_m ();
  sipo_deser_if #(.WIDTH(4)) b_l ();
  sipo_deser_if #(.WIDTH(8)) b_8 ();

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst(rst), .bus(b_m.slave));
  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst(rst), .bus(b_l.slave));
  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_8 (.clk(clk), .rst(rst), .bus(b_8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboards: a transfer happens on the next edge when valid & ready are both high now
  always @(negedge clk) begin
    if (rst && b_m.pout_valid && b_m.pout_ready) begin
      if (q_m.size() == 0) chk("m_unexpected_word", 32'(b_m.pout), 32'hdead);
      else chk("m_word", 32'(b_m.pout), 32'(q_m.pop_front()));
    end
    if (rst && b_l.pout_valid && b_l.pout_ready) begin
      if (q_l.size() == 0) chk("l_unexpected_word", 32'(b_l.pout), 32'hdead);
      else chk("l_word", 32'(b_l.pout), 32'(q_l.pop_front()));
    end
    if (rst && b_8.pout_valid && b_8.pout_ready) begin
      if (q_8.size() == 0) chk("w8_unexpected_word", 32'(b_8.pout), 32'hdead);
      else chk("w8_word", 32'(b_8.pout), 32'(q_8.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put4(input logic en, input logic b);
    b_m.si_en = en; b_l.si_en = en;
    b_m.si    = b;  b_l.si    = b;
    tick();
    b_m.si_en = 1'b0; b_l.si_en = 1'b0;
  endtask

  task automatic set4(input logic rdy, input logic fl, input logic clr);
    b_m.pout_ready = rdy; b_l.pout_ready = rdy;
    b_m.flush      = fl;  b_l.flush      = fl;
    b_m.ovf_clr    = clr; b_l.ovf_clr    = clr;
  endtask

  // s[3] is sent first: MSB-first word equals s, LSB-first word is s bit-reversed
  task automatic send4(input logic [3:0] s, input logic push, input logic rdy_last,
                       input logic clr_last);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) begin
        if (push) begin
          q_m.push_back(s);
          q_l.push_back({s[0], s[1], s[2], s[3]});
        end
        if (rdy_last) begin b_m.pout_ready = 1'b1; b_l.pout_ready = 1'b1; end
        if (clr_last) begin b_m.ovf_clr = 1'b1; b_l.ovf_clr = 1'b1; end
      end
      put4(1'b1, s[i]);
    end
    b_m.ovf_clr = 1'b0; b_l.ovf_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] s1;
    logic [7:0] s8;
    rst = 1'b0;
    set4(1'b0, 1'b0, 1'b0);
    b_m.si = 1'b0; b_l.si = 1'b0; b_m.si_en = 1'b0; b_l.si_en = 1'b0;
    b_8.si = 1'b0; b_8.si_en = 1'b0; b_8.flush = 1'b0; b_8.pout_ready = 1'b0; b_8.ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_pout", 32'(b_m.pout), 32'h0);
    chk("rst_valid", 32'(b_m.pout_valid), 32'h0);
    chk("rst_cnt", 32'(b_m.bit_cnt), 32'h0);
    chk("rst_ovf", 32'(b_m.overflow), 32'h0);
    #2 rst = 1'b1;
    tick();

    // basic word, both bit orders, bit_cnt sequence and one-cycle valid
    set4(1'b1, 1'b0, 1'b0);
    s1 = 4'b1101;
    q_m.push_back(4'b1101);
    q_l.push_back(4'b1011);
    for (int i = 3; i >= 0; i--) begin
      put4(1'b1, s1[i]);
      chk("t1_cnt", 32'(b_m.bit_cnt), 32'((4 - i) % 4));
    end
    chk("t1_valid", 32'(b_m.pout_valid), 32'h1);
    chk("t1_pout_m", 32'(b_m.pout), 32'hd);
    chk("t1_pout_l", 32'(b_l.pout), 32'hb);
    put4(1'b0, 1'b0);
    chk("t1_valid_drop", 32'(b_m.pout_valid), 32'h0);

    // same stream with gaps between bits
    q_m.push_back(4'b1101);
    q_l.push_back(4'b1011);
    for (int i = 3; i >= 0; i--) begin
      put4(1'b1, s1[i]);
      put4(1'b0, ~s1[i]);
      chk("t2_cnt_hold", 32'(b_l.bit_cnt), 32'((4 - i) % 4));
    end
    chk("t2_pout_l", 32'(b_l.pout), 32'hb);
    tick();

    // backpressure and overflow
    set4(1'b0, 1'b0, 1'b0);
    send4(4'b1101, 1'b1, 1'b0, 1'b0);
    send4(4'b0110, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf", 32'(b_m.overflow), 32'h1);
    chk("t3_pout_hold", 32'(b_m.pout), 32'hd);
    chk("t3_valid_hold", 32'(b_m.pout_valid), 32'h1);
    set4(1'b1, 1'b0, 1'b0);
    tick();
    chk("t3_valid_after_xfer", 32'(b_m.pout_valid), 32'h0);
    chk("t3_pout_after_xfer", 32'(b_m.pout), 32'hd);
    set4(1'b0, 1'b0, 1'b1);
    tick();
    set4(1'b0, 1'b0, 1'b0);
    chk("t3_ovf_clr", 32'(b_m.overflow), 32'h0);

    // drop coinciding with clear keeps the flag set
    send4(4'b1001, 1'b1, 1'b0, 1'b0);
    send4(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("t3_set_wins", 32'(b_l.overflow), 32'h1);
    set4(1'b1, 1'b0, 1'b1);
    tick();
    set4(1'b0, 1'b0, 1'b0);
    chk("t3_drained", 32'(b_m.pout_valid), 32'h0);
    chk("t3_ovf_clr2", 32'(b_m.overflow), 32'h0);

    // transfer and completion on the same edge
    send4(4'b1101, 1'b1, 1'b0, 1'b0);
    send4(4'b0011, 1'b1, 1'b1, 1'b0);
    chk("t4_pout_m", 32'(b_m.pout), 32'h3);
    chk("t4_pout_l", 32'(b_l.pout), 32'hc);
    chk("t4_valid", 32'(b_m.pout_valid), 32'h1);
    chk("t4_ovf", 32'(b_m.overflow), 32'h0);
    tick();
    chk("t4_valid_drop", 32'(b_m.pout_valid), 32'h0);

    // flush beats si_en
    put4(1'b1, 1'b1);
    put4(1'b1, 1'b1);
    set4(1'b1, 1'b1, 1'b0);
    put4(1'b1, 1'b1);
    set4(1'b1, 1'b0, 1'b0);
    chk("t5_cnt_flush", 32'(b_m.bit_cnt), 32'h0);
    send4(4'b0110, 1'b1, 1'b0, 1'b0);
    chk("t5_pout_m", 32'(b_m.pout), 32'h6);
    chk("t5_valid", 32'(b_l.pout_valid), 32'h1);
    tick();

    // asynchronous reset mid-cycle
    put4(1'b1, 1'b1);
    put4(1'b1, 1'b0);
    put4(1'b1, 1'b1);
    chk("t6_cnt_pre", 32'(b_m.bit_cnt), 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_pout", 32'(b_m.pout), 32'h0);
    chk("t6_rst_cnt", 32'(b_m.bit_cnt), 32'h0);
    chk("t6_rst_valid", 32'(b_l.pout_valid), 32'h0);
    chk("t6_rst_ovf", 32'(b_m.overflow), 32'h0);
    #3 rst = 1'b1;
    send4(4'b1001, 1'b1, 1'b0, 1'b0);
    chk("t6_pout_m", 32'(b_m.pout), 32'h9);
    chk("t6_pout_l", 32'(b_l.pout), 32'h9);
    tick();

    // 8-bit instance
    b_8.pout_ready = 1'b1;
    s8 = 8'b1101_0010;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) q_8.push_back(s8);
      b_8.si_en = 1'b1;
      b_8.si    = s8[i];
      tick();
      b_8.si_en = 1'b0;
      chk("w8_cnt", 32'(b_8.bit_cnt), 32'((8 - i) % 8));
    end
    chk("w8_valid", 32'(b_8.pout_valid), 32'h1);
    chk("w8_pout", 32'(b_8.pout), 32'hd2);
    tick();
    chk("w8_valid_drop", 32'(b_8.pout_valid), 32'h0);

    tick();
    chk("q_m_left", 32'(q_m.size()), 32'h0);
    chk("q_l_left", 32'(q_l.size()), 32'h0);
    chk("q_8_left", 32'(q_8.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
